// File: rtl/aes_inv_key_gen_pkg.sv
// Shared types, constants and byte/word helpers for the AES-128 inverse round-key generator.
package aes_inv_key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } state_e;

    localparam logic [3:0] AES_128_NUM_ROUNDS = 4'ha;
    localparam logic [7:0] RCON_INIT          = 8'h8d;
    localparam logic [7:0] RCON_LAST          = 8'h36;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
    endfunction

    // Exact inverse of xtime in GF(2^8): undo the reduction before shifting back.
    function automatic logic [7:0] inv_xtime(input logic [7:0] x);
        return x[0] ? (((x ^ 8'h1b) >> 1) | 8'h80) : (x >> 1);
    endfunction

    function automatic logic [31:0] rotword(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_inv_key_gen.sv
// On-the-fly AES-128 round-key generator producing keys from round 10 down to 0.
// Optional macro AES_INV_KEY_DIRECT_EN adds key_last to load a round-10 key directly.
module aes_inv_key_gen
    import aes_inv_key_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic [127:0] key,
    input  logic         init,
`ifdef AES_INV_KEY_DIRECT_EN
    input  logic         key_last,
`endif
    input  logic         next,
    output logic [127:0] round_key,
    output logic [3:0]   round,
    output logic         ready,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw
);

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         ready_q, ready_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  sub_rot;
    logic [7:0]   rc_fwd;
    logic [31:0]  k0, k1, k2, k3;
    logic [31:0]  p0, p1, p2, p3;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    assign sub_rot = rotword(new_sboxw);

    // Forward step: derive key r+1 from key r using rc[r+1].
    assign rc_fwd = xtime(rcon_q);
    assign k0 = w0 ^ sub_rot ^ {rc_fwd, 24'h0};
    assign k1 = w1 ^ k0;
    assign k2 = w2 ^ k1;
    assign k3 = w3 ^ k2;

    // Inverse step: w3^w2 recovers the previous w3, which is what feeds the S-box.
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;
    assign p0 = w0 ^ sub_rot ^ {rcon_q, 24'h0};

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        ready_d = ready_q;
        sboxw   = 32'h0;

        case (state_q)
            ST_EXPAND: begin
                sboxw   = w3;
                key_d   = {k0, k1, k2, k3};
                rcon_d  = rc_fwd;
                round_d = round_q + 4'd1;
                if (round_q + 4'd1 == AES_128_NUM_ROUNDS) begin
                    ready_d = 1'b1;
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                sboxw = p3;
                if (next && (round_q != 4'd0)) begin
                    key_d   = {p0, p1, p2, p3};
                    rcon_d  = inv_xtime(rcon_q);
                    round_d = round_q - 4'd1;
                end
            end
            default: begin
                sboxw = 32'h0;
            end
        endcase

        if (init) begin
            key_d   = key;
            round_d = 4'd0;
            rcon_d  = RCON_INIT;
            ready_d = 1'b0;
            state_d = ST_EXPAND;
        end

`ifdef AES_INV_KEY_DIRECT_EN
        if (init && key_last) begin
            round_d = AES_128_NUM_ROUNDS;
            rcon_d  = RCON_LAST;
            ready_d = 1'b1;
            state_d = ST_READY;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            key_q   <= 128'h0;
            round_q <= 4'd0;
            rcon_q  <= 8'h00;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            ready_q <= ready_d;
        end
    end

    assign round_key = key_q;
    assign round     = round_q;
    assign ready     = ready_q;

endmodule

// File: doc/aes_inv_key_gen.md
Name: aes_inv_key_gen

Overview:
On-the-fly AES-128 round-key generator for the decipher datapath. It delivers round keys in reverse order (round 10 down to 0), so the decipher does not need a 15-entry key memory. After init it forward-expands the cipher key internally to reach the round-10 key. Each subsequent next request then inverts one key-expansion step. It shares an external 4-byte S-box through the sboxw/new_sboxw port pair, the same way the forward key memory does.

Parameters:
none (AES-128 only; 10 rounds fixed in package constant)

Ports:
clk  input  1  clock
reset_n  input  1  reset, asynchronous, active-low
key  input  128  cipher key (round-0 key), sampled when init=1
init  input  1  start/restart; single-cycle pulse; priority over next
next  input  1  request previous round key; acted on only when ready=1 and round>0
round_key  output  128  current round key (registered)
round  output  4  index of round_key (0..10)
ready  output  1  round_key valid and next accepted
sboxw  output  32  word to external S-box (combinational)
new_sboxw  input  32  SubWord(sboxw), combinational same-cycle return

Behaviour:
- Reset values: round_key=0, round=0, ready=0, rcon_reg=8'h00, state=IDLE.
- Internal registers: key_reg (drives round_key), round_reg, rcon_reg, state.
- rcon_reg invariant: holds rc[round_reg]. rc[0]=8'h8d, rc[1]=8'h01, …, rc[10]=8'h36.
- xtime(x) = {x[6:0],0} ^ (8'h1b & {8{x[7]}}).
- inv_xtime(x) = x[0] ? (((x^8'h1b)>>1) | 8'h80) : (x>>1).
- Words: key_reg = {w0,w1,w2,w3}, with w0 in [127:96].
- States: IDLE, EXPAND, READY.
- init (any state, including mid-EXPAND):
  - key_reg<=key, round_reg<=0, rcon_reg<=8'h8d, ready<=0, state<=EXPAND.
- EXPAND, each cycle:
  - sboxw=w3; rc'=xtime(rcon_reg); t={new_sboxw[23:0],new_sboxw[31:24]}^{rc',24'h0}.
  - k0=w0^t, k1=w1^k0, k2=w2^k1, k3=w3^k2.
  - key_reg<={k0..k3}, rcon_reg<=rc', round_reg++.
  - On the edge where round_reg becomes 10: ready<=1 and state<=READY.
  - Latency: ready is high 10 cycles after the init edge, with round=10 and rcon_reg=8'h36.
- READY:
  - sboxw=w3^w2 (always driven).
  - next=1 and round_reg>0: one-cycle inverse step.
    - p3=w3^w2, p2=w2^w1, p1=w1^w0.
    - p0=w0^{new_sboxw[23:0],new_sboxw[31:24]}^{rcon_reg,24'h0}.
    - key_reg<={p0..p3}, rcon_reg<=inv_xtime(rcon_reg), round_reg--.
    - ready stays 1; back-to-back next yields one key per cycle.
  - next=1 at round_reg=0: ignored; all registers hold.
- IDLE: sboxw=0; next is ignored.
- Simultaneous init and next: init wins.
- ready=0 throughout EXPAND; next is ignored there.
- Reset asserted mid-operation: immediately returns all registers to reset values.

Optional Feature:
AES_INV_KEY_DIRECT_EN:
- Defined: adds input port key_last (1 bit). If init=1 and key_last=1, the block treats key as the round-10 key.
  - key_reg<=key, round_reg<=10, rcon_reg<=8'h36, state<=READY, ready<=1 on that same edge (1-cycle latency, EXPAND skipped).
  - init with key_last=0 behaves as the base design.
- Undefined: port absent; init always expands.

Decomposition:
- Package aes_inv_key_pkg:
  - state encoding.
  - AES_128_NUM_ROUNDS=4'ha, RCON_INIT=8'h8d, RCON_LAST=8'h36.
  - functions xtime, inv_xtime, rotword.
- No sub-module: the forward and inverse word transforms are small enough to stay inline. The S-box stays external.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, init pulse → ready rises 10 cycles later; round=10; round_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
- From that state, next for 10 consecutive cycles → round 9 = ac7766f319fadc2128d12941575c006e, …, round 1 = a0fafe1788542cb123a339392a6c7605, round 0 = original key; rcon_reg back to 8'h8d.
- At round 0, next held 3 cycles → round_key, round and ready unchanged.
- init issued at EXPAND cycle 5 with a new key → ready low; expansion restarts; ready 10 cycles after second init with the new key's round-10 key. Also assert init and next in the same cycle while READY → init wins.
- Reset pulse mid-reverse (round=4) → outputs 0 / ready 0 asynchronously; next ignored until the next init.
- With AES_INV_KEY_DIRECT_EN: init + key_last=1 + key=d014f9a8…0ca6 → ready 1 cycle later at round 10; one next → ac7766f3…006e.
